// File: rtl/somador_datapath_if.sv
// ---------------------------------------------------------------------------
// somador_datapath_if
// Purpose : bundles the adder FSM control lines, the external preload/readback
//           port and the datapath status outputs into one interface.
// Signals : address, rden, wren, load, transf, clear, ready  (FSM control)
//           ext_we, ext_addr, ext_wdata, ext_rdata           (external port)
//           acc, result, done, ovf, err                      (status)
// Modports: master - FSM/top level side (drives control, observes status)
//           slave  - datapath side
// ---------------------------------------------------------------------------
interface somador_datapath_if #(
   parameter int WIDTH = 16
);
   logic [4:0]       address;
   logic             rden;
   logic             wren;
   logic             load;
   logic             transf;
   logic             clear;
   logic             ready;
   logic             ext_we;
   logic [4:0]       ext_addr;
   logic [WIDTH-1:0] ext_wdata;
   logic [WIDTH-1:0] ext_rdata;
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] result;
   logic             done;
   logic             ovf;
   logic             err;

   modport master (
      output address, rden, wren, load, transf, clear, ready,
      output ext_we, ext_addr, ext_wdata,
      input  ext_rdata, acc, result, done, ovf, err
   );

   modport slave (
      input  address, rden, wren, load, transf, clear, ready,
      input  ext_we, ext_addr, ext_wdata,
      output ext_rdata, acc, result, done, ovf, err
   );
endinterface

// File: rtl/somador_datapath.sv
// ---------------------------------------------------------------------------
// somador_datapath
// Purpose : adder datapath. 32-word memory, read-data register, accumulator,
//           transfer register and result capture, steered by the adder FSM.
// Ports   : clk   - clock, all state updates on the rising edge
//           reset - asynchronous active-low reset
//           bus   - somador_datapath_if.slave (FSM control, external
//                   preload/readback port, acc/result/done/ovf/err status)
// Option  : SOMADOR_SATURATE_EN - when defined the accumulator saturates to
//           all-ones on carry-out instead of wrapping; ovf is set either way.
// ---------------------------------------------------------------------------
module somador_datapath #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 32
) (
   input  logic                clk,
   input  logic                reset,
   somador_datapath_if.slave   bus
);

`ifdef SOMADOR_SATURATE_EN
   localparam bit SAT_EN = 1'b1;
`else
   localparam bit SAT_EN = 1'b0;
`endif

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [WIDTH-1:0] r_rdata;
   logic [WIDTH-1:0] r_acc;
   logic [WIDTH-1:0] r_tr;
   logic [WIDTH-1:0] r_result;
   logic             r_ready_d;
   logic             r_done;
   logic             r_ovf;
   logic             r_err;

   logic [WIDTH:0]   w_sum;
   logic             w_ext_ok;
   logic             w_conflict;

   // Carry-out either wraps (low bits) or pins the accumulator at all-ones.
   function automatic logic [WIDTH-1:0] acc_update(input logic [WIDTH:0] s);
      if (SAT_EN && s[WIDTH])
         acc_update = '1;
      else
         acc_update = s[WIDTH-1:0];
   endfunction

   assign w_sum      = {1'b0, r_acc} + {1'b0, r_rdata};
   // External writes only land while the FSM is idle and not writing itself.
   assign w_ext_ok   = bus.ext_we & bus.ready & ~bus.wren;
   assign w_conflict = bus.load & bus.transf;

   // Memory: FSM write-back has the port; reads below see the pre-edge value.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      end else if (bus.wren) begin
         r_mem[bus.address] <= r_tr;
      end else if (w_ext_ok) begin
         r_mem[bus.ext_addr] <= bus.ext_wdata;
      end
   end

   // Read register, accumulator, transfer register and error flag.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_rdata <= '0;
         r_acc   <= '0;
         r_tr    <= '0;
         r_ovf   <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         if (bus.rden) r_rdata <= r_mem[bus.address];

         if (bus.clear) begin
            r_acc <= '0;
            r_ovf <= 1'b0;
         end else if (bus.load && !bus.transf) begin
            r_acc <= acc_update(w_sum);
            if (w_sum[WIDTH]) r_ovf <= 1'b1;
         end

         // Transfer takes the accumulator value present before this edge.
         if (bus.transf && !bus.load) r_tr <= r_acc;

         if (w_conflict || (bus.wren && bus.transf)) r_err <= 1'b1;
      end
   end

   // Result capture on the rising edge of ready, with a one-cycle done pulse.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_ready_d <= 1'b0;
         r_done    <= 1'b0;
         r_result  <= '0;
      end else begin
         r_ready_d <= bus.ready;
         r_done    <= bus.ready & ~r_ready_d;
         if (bus.ready && !r_ready_d) r_result <= r_acc;
      end
   end

   assign bus.ext_rdata = r_mem[bus.ext_addr];
   assign bus.acc       = r_acc;
   assign bus.result    = r_result;
   assign bus.done      = r_done;
   assign bus.ovf       = r_ovf;
   assign bus.err       = r_err;

endmodule

// File: tb/tb_somador_datapath.sv
// ---------------------------------------------------------------------------
// tb_somador_datapath
// Purpose : directed self-checking bench for somador_datapath.
// ---------------------------------------------------------------------------
module tb_somador_datapath;

   logic clk;
   logic reset;
   int   n_asserts;
   int   n_fail;

   somador_datapath_if #(.WIDTH(16)) bus ();

   somador_datapath #(.WIDTH(16), .DEPTH(32)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asserts++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic mem_chk(input string tag, input logic [4:0] a, input logic [15:0] exp);
      bus.ext_addr = a;
      #1;
      check(tag, {16'h0, bus.ext_rdata}, {16'h0, exp});
   endtask

   task automatic preload(input logic [4:0] a, input logic [15:0] d);
      bus.ext_we    = 1'b1;
      bus.ext_addr  = a;
      bus.ext_wdata = d;
      step();
      bus.ext_we    = 1'b0;
   endtask

   initial begin
      n_asserts = 0;
      n_fail    = 0;
      reset = 1'b0;
      bus.address = '0; bus.rden = 0; bus.wren = 0; bus.load = 0;
      bus.transf = 0; bus.clear = 0; bus.ready = 0; bus.ext_we = 0;
      bus.ext_addr = '0; bus.ext_wdata = '0;
      #12;
      check("rst_acc",    {16'h0, bus.acc},    32'd0);
      check("rst_result", {16'h0, bus.result}, 32'd0);
      check("rst_flags",  {29'h0, bus.done, bus.ovf, bus.err}, 32'd0);
      mem_chk("rst_mem0", 5'd0, 16'h0);
      @(negedge clk);
      reset = 1'b1;

      // Preload mem[k] = k+1 while idle; first ready edge captures acc=0.
      bus.ready = 1'b1;
      preload(5'd0, 16'd1);
      check("done_first", {31'h0, bus.done}, 32'd1);
      check("result_first", {16'h0, bus.result}, 32'd0);
      for (int k = 1; k < 32; k++) preload(k[4:0], 16'(k + 1));
      check("done_low", {31'h0, bus.done}, 32'd0);
      mem_chk("pre_mem5", 5'd5, 16'd6);
      mem_chk("pre_mem31", 5'd31, 16'd32);

      // FSM-style accumulation of all 32 words.
      bus.ready = 1'b0;
      bus.clear = 1'b1; step(); bus.clear = 1'b0;
      bus.rden = 1'b1; bus.address = 5'd0; step();
      bus.load = 1'b1;
      for (int k = 1; k < 32; k++) begin
         bus.address = k[4:0];
         step();
      end
      bus.rden = 1'b0; step(); bus.load = 1'b0;
      check("sum_acc", {16'h0, bus.acc}, 32'd528);
      check("sum_ovf", {31'h0, bus.ovf}, 32'd0);
      bus.transf = 1'b1; step(); bus.transf = 1'b0;
      bus.wren = 1'b1; bus.address = 5'd31; step(); bus.wren = 1'b0;
      mem_chk("wb_mem31", 5'd31, 16'd528);
      bus.ready = 1'b1; step();
      check("done_pulse", {31'h0, bus.done}, 32'd1);
      check("result_528", {16'h0, bus.result}, 32'd528);
      check("err_clean", {31'h0, bus.err}, 32'd0);
      step();
      check("done_one_cycle", {31'h0, bus.done}, 32'd0);
      check("result_hold", {16'h0, bus.result}, 32'd528);

      // Overflow: 0xFFFF + 0x0002.
      preload(5'd0, 16'hFFFF);
      preload(5'd1, 16'h0002);
      preload(5'd2, 16'd7);
      preload(5'd3, 16'd9);
      preload(5'd4, 16'd5);
      preload(5'd6, 16'd40);
      bus.ready = 1'b0;
      bus.clear = 1'b1; step(); bus.clear = 1'b0;
      bus.rden = 1'b1; bus.address = 5'd0; step();
      bus.load = 1'b1; bus.address = 5'd1; step();
      bus.rden = 1'b0; step(); bus.load = 1'b0;
`ifdef SOMADOR_SATURATE_EN
      check("ovf_acc", {16'h0, bus.acc}, 32'h0000FFFF);
`else
      check("ovf_acc", {16'h0, bus.acc}, 32'h00000001);
`endif
      check("ovf_flag", {31'h0, bus.ovf}, 32'd1);

      // Clear has priority over load (rdata=7, acc=9).
      bus.clear = 1'b1; bus.rden = 1'b1; bus.address = 5'd3; step();
      bus.clear = 1'b0; bus.rden = 1'b0; bus.load = 1'b1; step();
      bus.load = 1'b0; bus.rden = 1'b1; bus.address = 5'd2; step();
      bus.rden = 1'b0;
      check("pre_clear_acc", {16'h0, bus.acc}, 32'd9);
      bus.clear = 1'b1; bus.load = 1'b1; step();
      bus.clear = 1'b0; bus.load = 1'b0;
      check("clear_load_acc", {16'h0, bus.acc}, 32'd0);
      check("clear_load_ovf", {31'h0, bus.ovf}, 32'd0);

      // load and transf together: error, acc and tr_reg hold.
      bus.rden = 1'b1; bus.address = 5'd4; step();
      bus.rden = 1'b0; bus.load = 1'b1; step();
      check("acc_five", {16'h0, bus.acc}, 32'd5);
      bus.transf = 1'b1; step();
      bus.load = 1'b0; bus.transf = 1'b0;
      check("viol_err", {31'h0, bus.err}, 32'd1);
      check("viol_acc_hold", {16'h0, bus.acc}, 32'd5);
      bus.wren = 1'b1; bus.address = 5'd10; step(); bus.wren = 1'b0;
      mem_chk("viol_tr_hold", 5'd10, 16'd528);

      // Same-address read and write: read returns old word.
      bus.transf = 1'b1; step(); bus.transf = 1'b0;
      bus.rden = 1'b1; bus.wren = 1'b1; bus.address = 5'd10; step();
      bus.rden = 1'b0; bus.wren = 1'b0; bus.load = 1'b1; step();
      bus.load = 1'b0;
      check("rbw_acc", {16'h0, bus.acc}, 32'd533);
      mem_chk("rbw_mem10", 5'd10, 16'd5);
      check("err_sticky", {31'h0, bus.err}, 32'd1);

      // External writes ignored when not idle or when the FSM writes.
      bus.ext_we = 1'b1; bus.ext_addr = 5'd3; bus.ext_wdata = 16'h1234; step();
      bus.ext_we = 1'b0;
      mem_chk("extwe_notready", 5'd3, 16'd9);
      bus.ready = 1'b1; bus.wren = 1'b1; bus.address = 5'd20;
      bus.ext_we = 1'b1; bus.ext_addr = 5'd3; bus.ext_wdata = 16'h1234; step();
      bus.ready = 1'b0; bus.wren = 1'b0; bus.ext_we = 1'b0;
      mem_chk("extwe_wren", 5'd3, 16'd9);
      mem_chk("fsm_wr_mem20", 5'd20, 16'd5);
      check("result_533", {16'h0, bus.result}, 32'd533);

      // Asynchronous reset in the middle of accumulation.
      bus.clear = 1'b1; step(); bus.clear = 1'b0;
      bus.rden = 1'b1; bus.address = 5'd6; step();
      bus.rden = 1'b0; bus.load = 1'b1; step();
      check("acc_forty", {16'h0, bus.acc}, 32'd40);
      #3;
      reset = 1'b0;
      #1;
      check("arst_acc",    {16'h0, bus.acc},    32'd0);
      check("arst_result", {16'h0, bus.result}, 32'd0);
      check("arst_flags",  {29'h0, bus.done, bus.ovf, bus.err}, 32'd0);
      for (int a = 0; a < 32; a++) mem_chk("arst_mem", a[4:0], 16'h0);
      bus.load = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule

// File: doc/somador_datapath.md
Name: somador_datapath

Overview:
- Datapath driven by the adder FSM's control outputs (address, rden, wren, load, transf, clear, ready).
- Holds a 32-word operand/result memory, a read-data register, an accumulator and a transfer register.
- Reads words, accumulates them, transfers the sum and writes it back.
- Provides a preload/readback port for the bench and top level, and flags protocol violations and overflow.

Parameters:
- WIDTH, 16, data word width in bits.
- DEPTH, 32, memory words; fixed to match the 5-bit address.

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- address  in  5  memory address from FSM.
- rden  in  1  FSM read enable.
- wren  in  1  FSM write enable.
- load  in  1  accumulate read data into accumulator.
- transf  in  1  copy accumulator into transfer register.
- clear  in  1  zero accumulator and overflow flag.
- ready  in  1  FSM idle/done indication.
- ext_we  in  1  external memory write strobe.
- ext_addr  in  5  external access address.
- ext_wdata  in  WIDTH  external write data.
- ext_rdata  out  WIDTH  combinational read of mem[ext_addr].
- acc  out  WIDTH  accumulator value.
- result  out  WIDTH  sum captured at ready rising edge.
- done  out  1  one-cycle pulse when result is captured.
- ovf  out  1  sticky accumulation overflow.
- err  out  1  sticky protocol-violation flag.

Behaviour:
- Reset (reset=0, asynchronous):
  - all memory words = 0;
  - rdata, acc, tr_reg, result = 0;
  - done, ovf, err = 0;
  - ready_d (registered ready) = 0.
- Read: rden=1 -> rdata <= mem[address]; 1-cycle latency. rdata holds when rden=0.
- Write: wren=1 -> mem[address] <= tr_reg.
- Same-address rden and wren in one cycle: read returns the old data (read-before-write).
- Accumulate: load=1 and clear=0 -> acc <= acc + rdata, unsigned modulo 2^WIDTH. Carry-out sets ovf.
- Clear: clear=1 -> acc <= 0 and ovf <= 0. Clear has priority over load.
- Transfer: transf=1 -> tr_reg <= acc, the value before any same-cycle load.
- Protocol violation, load=1 and transf=1 together:
  - err <= 1;
  - acc and tr_reg hold;
  - err clears only on reset.
- Violation, wren=1 while transf=1: err <= 1; the memory write still occurs with the old tr_reg.
- Done/result:
  - ready_d <= ready every cycle;
  - ready=1 and ready_d=0 (rising edge) -> result <= acc and done=1 for exactly one cycle;
  - result holds otherwise.
- External write: ext_we=1 is accepted only when ready=1 and wren=0; otherwise it is ignored with no error.
- ext_rdata is always mem[ext_addr], combinational.
- Address 31 -> 0 wrap is the FSM's responsibility; the datapath decodes all 32 addresses.
- Reset mid-operation: everything returns to reset values immediately; memory contents are lost.

Optional Feature:
- Macro: SOMADOR_SATURATE_EN.
- Defined: on carry-out, acc <= all-ones (2^WIDTH-1) instead of wrapping; ovf is still set.
- Undefined: modulo wrap as described above.

Test Plan:
- Preload mem[0..31]=k+1 via ext_we with ready=1, then run FSM-style sequence (rden, load per address, transf, wren to address 31) -> acc=528, mem[31]=528, done pulse, result=528, ovf=0.
- Preload mem[0]=0xFFFF, mem[1]=0x0002, load both -> acc=0x0001, ovf=1; with SOMADOR_SATURATE_EN -> acc=0xFFFF, ovf=1.
- Assert load and transf in the same cycle with acc=5 -> err=1, acc=5, tr_reg unchanged; err stays 1 until reset.
- Assert clear and load together with rdata=7, acc=9 -> acc=0, ovf=0.
- ext_we with ready=0 to mem[3]=0x1234 -> mem[3] unchanged (ext_rdata shows old value).
- Pull reset low mid-accumulation (acc=40) -> acc, result, ovf, err, done = 0 asynchronously; ext_rdata=0 at every address.
